// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: request/ready fetch into a small {PC, instr} FIFO feeding decode.
// Redirects flush the FIFO; a request left hanging by the redirect is drained in DISCARD.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirectPC,
  input  logic                     stall,
  output logic                     memReq,
  output logic [31:0]              memAddr,
  input  logic                     memReady,
  input  logic [31:0]              memData,
  output logic                     valid,
  output logic [31:0]              instrOut,
  output logic [31:0]              pcOut,
  output logic [31:0]              pcPlus4Out,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t         state_q, state_d;
  logic [31:0]    fetch_pc, discard_addr;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count_q;
  logic [31:0]    pc_mem    [DEPTH];
  logic [31:0]    instr_mem [DEPTH];
  logic           xfer, push, pop;

  // rst gates memReq so no request is presented while reset is held
  assign memReq  = !rst && ((state_q == DISCARD) || (count_q != FULL));
  assign memAddr = (state_q == DISCARD) ? discard_addr : fetch_pc;
  assign xfer    = memReq && memReady;
  assign push    = xfer && (state_q == FETCH) && !redirect;
  assign pop     = valid && !stall && !redirect;

  assign count      = count_q;
  assign valid      = (count_q != '0);
  assign instrOut   = valid ? instr_mem[rd_ptr] : NOP;
  assign pcOut      = valid ? pc_mem[rd_ptr] : 32'h0;
  assign pcPlus4Out = valid ? pc_mem[rd_ptr] + 32'd4 : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (redirect && memReq && !memReady) state_d = DISCARD;
      DISCARD: if (memReady) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc     <= RESET_PC;
      discard_addr <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
    end else if (redirect) begin
      fetch_pc <= redirectPC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      // the abandoned address must stay on memAddr until memory accepts it
      if (state_q == FETCH && state_d == DISCARD) discard_addr <= fetch_pc;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= memData;
    end
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch buffer between the instruction memory and the IF/ID pipeline register of the pipelined RISC-V core. It drives a request/ready fetch interface that tolerates memory wait states, queues fetched {PC, instruction} pairs in a small FIFO, and presents the head entry to decode. It absorbs decode stalls (StallD) and discards all queued and in-flight fetches on an execute-stage redirect (PCSrcE ≠ 0).

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- redirect  in  1  taken branch/jump from execute; flush and refetch.
- redirectPC  in  32  new fetch address, valid when redirect=1.
- stall  in  1  decode not accepting; head entry held.
- memReq  out  1  fetch request.
- memAddr  out  32  fetch address, word aligned.
- memReady  in  1  memory accepts request; memData valid in the same cycle.
- memData  in  32  instruction word.
- valid  out  1  head entry present.
- instrOut  out  32  head instruction; 32'h0000_0013 (nop) when valid=0.
- pcOut  out  32  head PC; 0 when valid=0.
- pcPlus4Out  out  32  pcOut+4, modulo 2^32; 0 when valid=0.
- count  out  log2(DEPTH)+1  current occupancy.

## Operation
- State: fetchPC (32), FIFO storage, read/write pointers, count, FSM {FETCH, DISCARD}.
- Reset values: fetchPC=RESET_PC, count=0, pointers=0, FSM=FETCH, memReq=0 during reset. valid=0, instrOut=nop, pcOut=0, pcPlus4Out=0.
- memReq = (FSM=DISCARD) or (FSM=FETCH and count<DEPTH).
- memAddr = fetchPC in FETCH. In DISCARD it is the held abandoned address.
- Handshake: a transfer occurs when memReq=1 and memReady=1. After memReq rises, memReq and memAddr hold stable until the transfer.
- Push: transfer in FETCH with redirect=0. The entry {fetchPC, memData} is written, and fetchPC advances by 4 (wraps at 2^32).
- Pop: valid=1, stall=0, redirect=0. The read pointer advances.
- count updates: push-only +1, pop-only −1, push and pop together leave count unchanged. A push at count=DEPTH cannot occur because memReq=0.
- redirect has priority over push and pop. On the next edge: count=0, pointers=0, fetchPC=redirectPC.
  - If a request is outstanding without ready (memReq=1, memReady=0), FSM goes to DISCARD and keeps the old address on memAddr.
  - If the redirect cycle also contains a transfer, that data is dropped and FSM stays FETCH.
- DISCARD: memReq=1, memAddr=abandoned address. On memReady=1, the data is dropped and FSM goes to FETCH.
- redirect while in DISCARD: FSM stays DISCARD, FIFO stays empty, fetchPC takes the latest redirectPC.
- redirectPC[1:0] ≠ 0: the address is used unchanged and is not checked here.
- Reset mid-transfer: all state returns to reset values immediately. The pending memory request is abandoned without a handshake.

## Timing
- Fetch-to-decode latency is 1 cycle. A transfer at edge N makes valid=1 with that entry after edge N (visible in cycle N+1) when the FIFO was empty. There is no same-cycle bypass.
- Zero-wait memory with stall=0 sustains 1 instruction/cycle.
- A redirect asserted in cycle N gives valid=0 in cycle N+1. The earliest new entry is valid in cycle N+2 (FETCH), or 1 cycle after the DISCARD transfer.
- After a pop from a full FIFO, memReq re-asserts in the next cycle.
- All outputs depend only on registers, except memReq/memAddr, which are combinational from FSM, count and fetchPC (no input-to-output paths).

## Test plan
- Release reset, memReady=1, stall=0, DEPTH=4, memory returns word = 0xA000_0000|addr.
  - memAddr goes 0,4,8,…
  - valid rises one cycle after the first transfer.
  - instrOut/pcOut stream 0xA000_0000/0, 0xA000_0004/4, … with pcPlus4Out = pcOut+4.
- Hold stall=1 from the first valid.
  - count reaches 4, then memReq=0 and memAddr stays 0x10.
  - Release stall: one pop per cycle, memReq=1 the cycle after count=3, and no PC gaps or duplicates.
- memReady=0 for 3 cycles while the FIFO is empty.
  - memReq=1 and memAddr constant throughout; valid=0.
  - The transfer occurs on the 4th cycle, and valid=1 the next cycle.
- Outstanding request at 0x8 with memReady=0, then redirect=1 with redirectPC=0x100.
  - Next cycle: count=0 and memAddr still 0x8 (DISCARD).
  - memReady=1: the data is dropped.
  - Next request has memAddr=0x100; the first valid entry has pcOut=0x100.
- count=2, stall=0, and a transfer in the same cycle as redirect to 0x200.
  - No push, no pop; next cycle count=0, FSM=FETCH, memAddr=0x200.
- Assert rst asynchronously mid-cycle with count=3.
  - Immediately: valid=0, instrOut=0x13, pcOut=0, count=0, memReq=0.
  - After release, fetch restarts at RESET_PC.
